// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse synchroniser bank: edge-mode encodings
// and small helpers used to size and summarise the pulse vector.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when at least two bits are set: clearing the lowest set bit
  // leaves something behind only if a second bit was present.
  function automatic logic popcount_ge2(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: metastability chain, debounce counter, debounced level and
// a registered single-cycle edge pulse.
module sync_debounce_ch
  import pulse_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int          EDGE_MODE       = 0,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  input  logic enable_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_d_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_out;
  logic                   edge_ok;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Transition direction towards sync_out that this channel reports.
  assign edge_ok = (EDGE_MODE == int'(EDGE_BOTH)) ||
                   ((EDGE_MODE == int'(EDGE_RISE)) ? sync_out : !sync_out);

  // Synchroniser shift register; only the last stage is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Debounce: a differing level must persist DEBOUNCE_CYCLES clocks.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_out;
      cnt_d   = '0;
      pulse_d = enable_i && edge_ok;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;

endmodule

// File: rtl/pulse_sync_bank.sv
// Multi-channel async input synchroniser/debouncer with a registered
// summary (valid, lowest pulsing index, collision) for the accumulator FSM.
module pulse_sync_bank
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int          EDGE_MODE       = 0,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CHANNELS-1:0]                async_in,
  input  logic                               enable,
  output logic [CHANNELS-1:0]                level_s,
  output logic [CHANNELS-1:0]                pulse,
  output logic                               any_valid,
  output logic [clog2_min1(CHANNELS)-1:0]    first_idx,
  output logic                               collision
);

  localparam int unsigned FW = clog2_min1(CHANNELS);

  logic [CHANNELS-1:0] pulse_d;
  logic [FW-1:0]       first_d, first_q;
  logic                any_q, coll_q;
  logic                found;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_i   (async_in[g]),
      .enable_i  (enable),
      .level_o   (level_s[g]),
      .pulse_o   (pulse[g]),
      .pulse_d_o (pulse_d[g])
    );
  end

  // Priority encoder over the next-state pulses, lowest index wins.
  always_comb begin
    first_d = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pulse_d[i] && !found) begin
        first_d = FW'(i);
        found   = 1'b1;
      end
    end
  end

  // Summary registers load alongside the channel pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q   <= 1'b0;
      first_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      any_q   <= |pulse_d;
      first_q <= first_d;
      coll_q  <= popcount_ge2(16'(pulse_d));
    end
  end

  assign any_valid = any_q;
  assign first_idx = first_q;
  assign collision = coll_q;

endmodule

// File: doc/pulse_sync_bank.md
Name: pulse_sync_bank

Overview:
- Parametrised, multi-channel successor to the per-coin input synchroniser in the vending-machine datapath.
- Each asynchronous input goes through an N-flop metastability chain, a per-channel debounce counter, and a configurable edge detector that emits exactly one clean clk-wide pulse per accepted transition.
- A registered summary (lowest active channel index, valid, collision) feeds the downstream coin-accumulator FSM.

Parameters:
- CHANNELS, 4, number of independent async inputs (1..16).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive clocks a new level must persist before acceptance (>=1).
- EDGE_MODE, 0, which transition pulses: 0 falling, 1 rising, 2 both.
- IDLE_LEVEL, 1, reset/idle value of every sync flop and debounced level.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- async_in  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
- enable  input  1  pulse enable; low masks pulses only, filtering keeps running.
- level_s  output  CHANNELS  debounced, synchronised level per channel.
- pulse  output  CHANNELS  one-cycle pulse per accepted edge.
- any_valid  output  1  OR of pulse.
- first_idx  output  $clog2(CHANNELS) (min 1)  lowest index with pulse set; 0 when none.
- collision  output  1  more than one pulse bit set this cycle.

Behaviour:
- Reset (rst_n low, asynchronous assert): all sync flops and level_s go to IDLE_LEVEL. Debounce counters, pulse, any_valid, first_idx and collision go to 0. Release is synchronous to clk via the normal logic path; no pulse may appear on release.
- Sync chain:
  - Shift register of SYNC_STAGES flops per channel.
  - The last stage is the only signal consumed downstream.
  - No combinational path from async_in.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If sync_out == level_s, the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, level_s takes sync_out and the counter clears.
  - Otherwise the counter increments.
  - Any glitch back to the stable value before acceptance restarts the count. The counter never wraps.
- Edge detect, registered on the same edge that updates level_s:
  - Falling = level_s 1 -> 0; rising = level_s 0 -> 1.
  - pulse[i] <= enable && (accepted transition matches EDGE_MODE).
  - In every other cycle pulse[i] is 0, so it is never high two cycles in a row.
- Latency: if async_in changes before edge k, sync_out changes at edge k+SYNC_STAGES-1. level_s and pulse change at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults, input change before edge 1 gives pulse high from edge 6 to edge 7.
- enable:
  - Sampled at the accepting edge.
  - Low means transitions are absorbed silently and level_s still updates.
  - Re-enabling never releases a stored or late pulse.
- Summary outputs:
  - Registered from the next-state pulse vector, so they are valid in the same cycle as pulse.
  - any_valid = |pulse.
  - first_idx = priority encoder, lowest index wins.
  - collision = popcount(pulse) >= 2.
- Simultaneous events: channels are fully independent, and simultaneous acceptances all pulse. collision flags them; no pulse is dropped.
- Reset mid-debounce discards the partial count. Reset during a pulse clears it immediately.
- Width rule: first_idx is 1 bit when CHANNELS == 1.

Decomposition:
- Package pulse_sync_pkg:
  - EDGE_FALL=0, EDGE_RISE=1, EDGE_BOTH=2.
  - Function clog2_min1(n), used for first_idx width.
  - Function popcount_ge2(vector) for collision.
- Sub-module sync_debounce_ch: one channel containing the sync chain, debounce counter, level_s and edge pulse. Parameters SYNC_STAGES, DEBOUNCE_CYCLES, EDGE_MODE, IDLE_LEVEL.
- Top: generate loop over CHANNELS plus the summary register stage.

Test Plan:
1. Defaults; hold async_in[2] low from before edge 1 -> level_s[2]=0 and pulse=4'b0100 for exactly one cycle starting at edge 6; first_idx=2, any_valid=1, collision=0.
2. async_in[0] low for 3 clocks then back high (glitch shorter than DEBOUNCE_CYCLES=4) -> level_s[0] stays 1, pulse never asserts.
3. Channels 1 and 3 fall in the same cycle -> pulse=4'b1010 for one cycle, first_idx=1, collision=1.
4. enable=0 while channel 0 falls, then enable=1 -> level_s[0]=0, no pulse at any time; a later rise with EDGE_MODE=2 produces exactly one pulse.
5. EDGE_MODE=2, channel 1 falls then rises, each held 10 clocks -> two single-cycle pulses on pulse[1], 10 cycles apart.
6. rst_n asserted mid-debounce (counter=2) -> outputs clear asynchronously; after release with async_in[0]=0 held, pulse[0] occurs at edge 6 after release, not earlier.
